// File: rtl/ctech_lib_clk_div_mon.sv
// ctech_lib_clk_div_mon: measures the period of a flop-divided clock in clk cycles, tracks lock and errors.
// Define CTECH_CLK_DIV_MON_DUTY_EN to add the high-time (duty) check and the meas_high output.
module ctech_lib_clk_div_mon #(
  parameter int unsigned CW       = 8,
  parameter int unsigned LOCK_CNT = 4
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          clkdiv_in,
  input  logic          enable,
  input  logic [CW-1:0] exp_period,
  input  logic [CW-1:0] tol,
  input  logic          err_clr,
  output logic [CW-1:0] meas_period,
  output logic          period_vld,
  output logic          locked,
  output logic          err,
`ifdef CTECH_CLK_DIV_MON_DUTY_EN
  output logic [CW-1:0] meas_high,
`endif
  output logic          err_sticky
);

  typedef enum logic [1:0] {ST_IDLE, ST_SYNC, ST_MEASURE, ST_LOCKED} state_e;

  localparam logic [CW-1:0] CNT_MAX  = '1;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [3:0]    LOCK_TGT = 4'(LOCK_CNT);

  state_e        state_q, state_d;
  logic          s1_q, s2_q, s3_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    good_q, good_d;
  logic [CW-1:0] meas_q, meas_d;
  logic          pv_q, pv_d;
  logic          locked_q, locked_d;
  logic          err_q, err_d;
  logic          sticky_q, sticky_d;
  logic          rise, stuck, period_ok, sample_ok;
  logic [CW:0]   per_w, exp_w, per_diff;

  assign rise  = s2_q & ~s3_q;
  assign stuck = (cnt_q == CNT_MAX);

  // One extra bit keeps cnt+1 and the absolute difference from wrapping.
  always_comb begin
    per_w     = {1'b0, cnt_q} + {1'b0, CNT_ONE};
    exp_w     = {1'b0, exp_period};
    per_diff  = (per_w >= exp_w) ? (per_w - exp_w) : (exp_w - per_w);
    period_ok = (per_diff <= {1'b0, tol});
  end

`ifdef CTECH_CLK_DIV_MON_DUTY_EN
  logic [CW-1:0] hi_q, hi_d;
  logic [CW-1:0] mhigh_q, mhigh_d;
  logic [CW:0]   high_w;
  logic [CW+1:0] dbl_high, per2_w, duty_diff;
  logic          duty_ok;

  // hi_q excludes the rise cycle itself, so the high time is hi_q+1.
  always_comb begin
    high_w    = {1'b0, hi_q} + {1'b0, CNT_ONE};
    dbl_high  = {high_w, 1'b0};
    per2_w    = {1'b0, per_w};
    duty_diff = (dbl_high >= per2_w) ? (dbl_high - per2_w) : (per2_w - dbl_high);
    duty_ok   = (duty_diff <= {2'b00, tol});
  end

  assign sample_ok = period_ok & duty_ok;

  always_comb begin
    hi_d    = hi_q;
    mhigh_d = mhigh_q;
    if (!enable || state_q == ST_IDLE) begin
      hi_d = '0;
    end else if (rise) begin
      hi_d = '0;
    end else if (s2_q && hi_q != CNT_MAX) begin
      hi_d = hi_q + CNT_ONE;
    end
    if (pv_d) begin
      mhigh_d = high_w[CW-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      hi_q    <= '0;
      mhigh_q <= '0;
    end else begin
      hi_q    <= hi_d;
      mhigh_q <= mhigh_d;
    end
  end

  assign meas_high = mhigh_q;
`else
  assign sample_ok = period_ok;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    good_d   = good_q;
    locked_d = locked_q;
    meas_d   = meas_q;
    pv_d     = 1'b0;
    err_d    = 1'b0;

    if (state_q != ST_IDLE) begin
      if (rise) begin
        cnt_d = '0;
      end else if (!stuck) begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_SYNC;
        end
      end
      ST_SYNC: begin
        if (rise) begin
          state_d = ST_MEASURE;
        end
      end
      ST_MEASURE: begin
        if (stuck) begin
          err_d   = 1'b1;
          good_d  = '0;
          state_d = ST_SYNC;
        end else if (rise) begin
          pv_d   = 1'b1;
          meas_d = per_w[CW-1:0];
          if (sample_ok) begin
            good_d = good_q + 4'd1;
            if (good_q + 4'd1 == LOCK_TGT) begin
              locked_d = 1'b1;
              state_d  = ST_LOCKED;
            end
          end else begin
            err_d  = 1'b1;
            good_d = '0;
          end
        end
      end
      ST_LOCKED: begin
        if (stuck) begin
          err_d    = 1'b1;
          locked_d = 1'b0;
          good_d   = '0;
          state_d  = ST_SYNC;
        end else if (rise) begin
          pv_d   = 1'b1;
          meas_d = per_w[CW-1:0];
          if (!sample_ok) begin
            err_d    = 1'b1;
            locked_d = 1'b0;
            good_d   = '0;
            state_d  = ST_MEASURE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Disable overrides everything except the held measurement.
    if (!enable) begin
      state_d  = ST_IDLE;
      cnt_d    = '0;
      good_d   = '0;
      locked_d = 1'b0;
      meas_d   = meas_q;
      pv_d     = 1'b0;
      err_d    = 1'b0;
    end

    sticky_d = err_d | (sticky_q & ~err_clr);
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q  <= ST_IDLE;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      s3_q     <= 1'b0;
      cnt_q    <= '0;
      good_q   <= '0;
      meas_q   <= '0;
      pv_q     <= 1'b0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      s1_q     <= clkdiv_in;
      s2_q     <= s1_q;
      s3_q     <= s2_q;
      cnt_q    <= cnt_d;
      good_q   <= good_d;
      meas_q   <= meas_d;
      pv_q     <= pv_d;
      locked_q <= locked_d;
      err_q    <= err_d;
      sticky_q <= sticky_d;
    end
  end

  assign meas_period = meas_q;
  assign period_vld  = pv_q;
  assign locked      = locked_q;
  assign err         = err_q;
  assign err_sticky  = sticky_q;

endmodule

// File: tb/tb_ctech_lib_clk_div_mon.sv
// Directed self-checking bench for ctech_lib_clk_div_mon (CW=8, LOCK_CNT=4).
// Duty scenario compiles in only when CTECH_CLK_DIV_MON_DUTY_EN is defined.
module tb_ctech_lib_clk_div_mon;

  localparam int unsigned CW = 8;

  logic          clk;
  logic          rst_b;
  logic          clkdiv_in;
  logic          enable;
  logic [CW-1:0] exp_period;
  logic [CW-1:0] tol;
  logic          err_clr;
  logic [CW-1:0] meas_period;
  logic          period_vld;
  logic          locked;
  logic          err;
  logic          err_sticky;
`ifdef CTECH_CLK_DIV_MON_DUTY_EN
  logic [CW-1:0] meas_high;
`endif

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  int   n_pv, n_err, n_lrise, n_lfall, pv_at_lock, cyc_idx, err_idx;
  logic lock_with_pv, lock_at_err, locked_prev;
  logic [CW-1:0] last_meas, min_meas, max_meas, last_high;

  ctech_lib_clk_div_mon #(.CW(CW), .LOCK_CNT(4)) dut (
    .clk        (clk),
    .rst_b      (rst_b),
    .clkdiv_in  (clkdiv_in),
    .enable     (enable),
    .exp_period (exp_period),
    .tol        (tol),
    .err_clr    (err_clr),
    .meas_period(meas_period),
    .period_vld (period_vld),
    .locked     (locked),
    .err        (err),
`ifdef CTECH_CLK_DIV_MON_DUTY_EN
    .meas_high  (meas_high),
`endif
    .err_sticky (err_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clr_stats();
    n_pv = 0; n_err = 0; n_lrise = 0; n_lfall = 0; pv_at_lock = -1;
    cyc_idx = 0; err_idx = -1; lock_with_pv = 1'b0; lock_at_err = 1'b1;
    last_meas = '0; min_meas = '1; max_meas = '0; last_high = '0;
  endtask

  // Drive one clk cycle of clkdiv_in from a negedge; record outputs at the next negedge.
  task automatic cyc(input logic v);
    clkdiv_in = v;
    @(negedge clk);
    if (period_vld) begin
      n_pv++;
      last_meas = meas_period;
      if (meas_period < min_meas) min_meas = meas_period;
      if (meas_period > max_meas) max_meas = meas_period;
`ifdef CTECH_CLK_DIV_MON_DUTY_EN
      last_high = meas_high;
`endif
    end
    if (err) begin
      n_err++;
      if (err_idx < 0) err_idx = cyc_idx;
      lock_at_err = locked;
    end
    if (locked && !locked_prev) begin
      n_lrise++;
      pv_at_lock   = n_pv;
      lock_with_pv = period_vld;
    end
    if (!locked && locked_prev) n_lfall++;
    locked_prev = locked;
    cyc_idx++;
  endtask

  task automatic pat(input int hi, input int lo, input int reps);
    for (int r = 0; r < reps; r++) begin
      for (int i = 0; i < hi; i++) cyc(1'b1);
      for (int i = 0; i < lo; i++) cyc(1'b0);
    end
  endtask

  task automatic restart(input logic [CW-1:0] e, input logic [CW-1:0] t);
    enable = 1'b0;
    cyc(1'b0); cyc(1'b0);
    exp_period = e;
    tol        = t;
    enable     = 1'b1;
    cyc(1'b0); cyc(1'b0); cyc(1'b0);
    clr_stats();
  endtask

  task automatic test_reset();
    rst_b = 1'b0; enable = 1'b0; clkdiv_in = 1'b0; err_clr = 1'b0;
    exp_period = '0; tol = '0; locked_prev = 1'b0;
    clr_stats();
    repeat (2) @(negedge clk);
    n_cmp++; if (meas_period !== 8'd0) begin n_bad++; $display("FAIL reset_meas: got %0d want 0", meas_period); end
    n_cmp++; if (period_vld !== 1'b0) begin n_bad++; $display("FAIL reset_pv: got %b want 0", period_vld); end
    n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL reset_locked: got %b want 0", locked); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", err); end
    n_cmp++; if (err_sticky !== 1'b0) begin n_bad++; $display("FAIL reset_sticky: got %b want 0", err_sticky); end
    rst_b = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_div2_lock();
    restart(8'd2, 8'd0);
    pat(1, 1, 12);
    pat(0, 4, 1);
    n_cmp++; if (n_pv !== 11) begin n_bad++; $display("FAIL div2_pv_count: got %0d want 11", n_pv); end
    n_cmp++; if (min_meas !== 8'd2 || max_meas !== 8'd2) begin n_bad++; $display("FAIL div2_meas: got min %0d max %0d want 2", min_meas, max_meas); end
    n_cmp++; if (n_err !== 0) begin n_bad++; $display("FAIL div2_no_err: got %0d want 0", n_err); end
    n_cmp++; if (pv_at_lock !== 4) begin n_bad++; $display("FAIL div2_lock_pv: got %0d want 4", pv_at_lock); end
    n_cmp++; if (lock_with_pv !== 1'b1) begin n_bad++; $display("FAIL div2_lock_with_pv: got %b want 1", lock_with_pv); end
    n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL div2_locked: got %b want 1", locked); end
  endtask

  task automatic test_period_err();
    err_clr = 1'b1; cyc(1'b0); err_clr = 1'b0;
    n_cmp++; if (err_sticky !== 1'b0) begin n_bad++; $display("FAIL perr_sticky_clear: got %b want 0", err_sticky); end
    restart(8'd4, 8'd1);
    pat(2, 2, 5);
    n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL perr_prelock: got %b want 1", locked); end
    clr_stats();
    pat(3, 3, 1);
    pat(2, 2, 5);
    pat(0, 3, 1);
    n_cmp++; if (n_err !== 1) begin n_bad++; $display("FAIL perr_err_count: got %0d want 1", n_err); end
    n_cmp++; if (lock_at_err !== 1'b0) begin n_bad++; $display("FAIL perr_lock_at_err: got %b want 0", lock_at_err); end
    n_cmp++; if (max_meas !== 8'd6) begin n_bad++; $display("FAIL perr_max_meas: got %0d want 6", max_meas); end
    n_cmp++; if (n_lfall !== 1 || n_lrise !== 1) begin n_bad++; $display("FAIL perr_lock_edges: got fall %0d rise %0d want 1 1", n_lfall, n_lrise); end
    n_cmp++; if (pv_at_lock !== 6) begin n_bad++; $display("FAIL perr_relock_pv: got %0d want 6", pv_at_lock); end
    n_cmp++; if (err_sticky !== 1'b1) begin n_bad++; $display("FAIL perr_sticky: got %b want 1", err_sticky); end
    n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL perr_relocked: got %b want 1", locked); end
  endtask

  task automatic test_stuck();
    restart(8'd4, 8'd1);
    pat(2, 2, 5);
    n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL stuck_prelock: got %b want 1", locked); end
    clr_stats();
    pat(270, 0, 1);
    n_cmp++; if (err_idx !== 258) begin n_bad++; $display("FAIL stuck_err_cycle: got %0d want 258", err_idx); end
    n_cmp++; if (n_err !== 1) begin n_bad++; $display("FAIL stuck_err_count: got %0d want 1", n_err); end
    n_cmp++; if (n_pv !== 1) begin n_bad++; $display("FAIL stuck_pv_count: got %0d want 1", n_pv); end
    n_cmp++; if (locked !== 1'b0 || n_lfall !== 1) begin n_bad++; $display("FAIL stuck_unlock: got locked %b falls %0d want 0 1", locked, n_lfall); end
    clr_stats();
    pat(0, 2, 1);
    pat(2, 2, 5);
    n_cmp++; if (pv_at_lock !== 4) begin n_bad++; $display("FAIL stuck_relock_pv: got %0d want 4", pv_at_lock); end
    n_cmp++; if (locked !== 1'b1 || n_err !== 0) begin n_bad++; $display("FAIL stuck_relock: got locked %b err %0d want 1 0", locked, n_err); end
  endtask

  task automatic test_err_clr_collision();
    restart(8'd4, 8'd0);
    n_cmp++; if (err_sticky !== 1'b1) begin n_bad++; $display("FAIL clr_sticky_held: got %b want 1", err_sticky); end
    pat(2, 2, 3);
    pat(3, 3, 1);
    cyc(1'b1);
    cyc(1'b1);
    n_cmp++; if (n_err !== 0) begin n_bad++; $display("FAIL clr_no_early_err: got %0d want 0", n_err); end
    err_clr = 1'b1;
    cyc(1'b0);
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL clr_collide_err: got %b want 1", err); end
    n_cmp++; if (err_sticky !== 1'b1) begin n_bad++; $display("FAIL clr_collide_sticky: got %b want 1", err_sticky); end
    cyc(1'b0);
    err_clr = 1'b0;
    n_cmp++; if (err_sticky !== 1'b0 || err !== 1'b0) begin n_bad++; $display("FAIL clr_alone: got sticky %b err %b want 0 0", err_sticky, err); end
  endtask

  task automatic test_reset_and_disable();
    restart(8'd4, 8'd1);
    pat(2, 2, 5);
    n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL rst_prelock: got %b want 1", locked); end
    #2 rst_b = 1'b0;
    #1;
    n_cmp++; if ({locked, err, err_sticky, period_vld} !== 4'b0000 || meas_period !== 8'd0) begin
      n_bad++; $display("FAIL rst_async: got lk/err/st/pv %b%b%b%b meas %0d want 0000 0", locked, err, err_sticky, period_vld, meas_period);
    end
    @(negedge clk);
    rst_b = 1'b1;
    clr_stats();
    pat(0, 3, 1);
    pat(2, 2, 5);
    cyc(1'b0);
    n_cmp++; if (pv_at_lock !== 4 || locked !== 1'b1) begin n_bad++; $display("FAIL rst_relock: got pv %0d locked %b want 4 1", pv_at_lock, locked); end
    restart(8'd4, 8'd1);
    pat(2, 2, 3);
    enable = 1'b0;
    pat(2, 2, 3);
    n_cmp++; if (n_pv !== 2) begin n_bad++; $display("FAIL dis_pv_count: got %0d want 2", n_pv); end
    n_cmp++; if (meas_period !== 8'd4) begin n_bad++; $display("FAIL dis_meas_held: got %0d want 4", meas_period); end
    enable = 1'b1;
    cyc(1'b0); cyc(1'b0);
    pat(2, 2, 4);
    n_cmp++; if (locked !== 1'b0 || n_lrise !== 0 || n_pv !== 5) begin n_bad++; $display("FAIL dis_no_lock: got locked %b rises %0d pv %0d want 0 0 5", locked, n_lrise, n_pv); end
    pat(2, 2, 1);
    n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL dis_relock: got %b want 1", locked); end
  endtask

`ifdef CTECH_CLK_DIV_MON_DUTY_EN
  task automatic test_duty();
    restart(8'd4, 8'd0);
    pat(2, 2, 4);
    n_cmp++; if (n_err !== 0 || n_pv !== 3) begin n_bad++; $display("FAIL duty_good: got err %0d pv %0d want 0 3", n_err, n_pv); end
    n_cmp++; if (last_high !== 8'd2) begin n_bad++; $display("FAIL duty_high2: got %0d want 2", last_high); end
    clr_stats();
    pat(3, 1, 2);
    pat(1, 3, 1);
    n_cmp++; if (n_err !== 2 || n_pv !== 3) begin n_bad++; $display("FAIL duty_bad: got err %0d pv %0d want 2 3", n_err, n_pv); end
    n_cmp++; if (last_high !== 8'd3 || last_meas !== 8'd4) begin n_bad++; $display("FAIL duty_high3: got high %0d per %0d want 3 4", last_high, last_meas); end
  endtask
`endif

  initial begin
    test_reset();
    test_div2_lock();
    test_period_err();
    test_stuck();
    test_err_clr_collision();
    test_reset_and_disable();
`ifdef CTECH_CLK_DIV_MON_DUTY_EN
    test_duty();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
